// File: rtl/instr_executor.sv
`default_nettype none
// ============================================================================
// Module      : instr_executor
// Description : Walks a batch of entries in a 32-entry instruction register
//               file, executes each one on a 64-bit signed ALU and presents
//               every result through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_executor (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic        [4:0]  start_ptr,
    input  logic        [5:0]  count,
    output logic        [4:0]  read_pointer,
    input  logic        [3:0]  rd_opcode,
    input  logic signed [31:0] rd_operand_a,
    input  logic signed [31:0] rd_operand_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic        [4:0]  res_ptr,
    output logic signed [63:0] res_value,
    output logic               res_error,
    output logic               busy,
    output logic               done
);

    localparam logic [5:0] C_MAX_COUNT = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_RESP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic        [4:0]   r_ptr;
    logic        [5:0]   r_remaining;
    logic signed [63:0]  w_a;
    logic signed [63:0]  w_b;
    logic signed [63:0]  w_b_safe;
    logic signed [63:0]  w_result;
    logic                w_error;
    logic        [5:0]   w_count_sat;

    // The register file is addressed straight from the entry pointer; the
    // address only matters while fetching, and it reads 0 out of reset.
    assign read_pointer = r_ptr;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign w_count_sat  = (count > C_MAX_COUNT) ? C_MAX_COUNT : count;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a handshake on the last remaining entry ends the batch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count == 6'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP: begin
                if (res_ready) begin
                    w_next_state = (r_remaining == 6'd1) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ALU: operands are widened to 64 bits so no result can overflow. The
    // divisor is forced non-zero so a zero divide never produces X; the
    // result of that path is replaced by the error value anyway.
    always_comb begin
        w_a      = {{32{rd_operand_a[31]}}, rd_operand_a};
        w_b      = {{32{rd_operand_b[31]}}, rd_operand_b};
        w_b_safe = (rd_operand_b == 32'sd0) ? 64'sd1 : w_b;
        w_result = 64'sd0;
        w_error  = 1'b0;
        case (rd_opcode)
            4'd0: w_result = 64'sd0;
            4'd1: w_result = w_a;
            4'd2: w_result = w_b;
            4'd3: w_result = w_a + w_b;
            4'd4: w_result = w_a - w_b;
            4'd5: w_result = w_a * w_b;
            4'd6: begin
                if (rd_operand_b == 32'sd0) begin
                    w_error = 1'b1;
                end else begin
                    w_result = w_a / w_b_safe;
                end
            end
            4'd7: begin
                if (rd_operand_b == 32'sd0) begin
                    w_error = 1'b1;
                end else begin
                    w_result = w_a % w_b_safe;
                end
            end
            default: w_error = 1'b1;
        endcase
    end

    // Batch pointer/counter and the registered result held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= 5'd0;
            r_remaining <= 6'd0;
            res_valid   <= 1'b0;
            res_ptr     <= 5'd0;
            res_value   <= 64'sd0;
            res_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (count != 6'd0)) begin
                        r_ptr       <= start_ptr;
                        r_remaining <= w_count_sat;
                    end
                end
                S_EXEC: begin
                    res_valid <= 1'b1;
                    res_ptr   <= r_ptr;
                    res_value <= w_result;
                    res_error <= w_error;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        r_ptr       <= r_ptr + 5'd1;
                        r_remaining <= r_remaining - 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
